shift_operand_stage: RTL

//  Registered issue stage directly upstream of the 16-bit shifter. Takes register-file operands for
//  LSH (register amount) and LSHI (immediate amount), decodes the signed shift count into

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_count_decode.sv | 16 +
 rtl/shift_operand_stage.sv | 70 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, FSM states and buffered-operation record for the shifter issue stage
package shift_pkg;
  localparam int DATAWIDTH = 16;
  localparam int AMTWIDTH = 5;
  localparam int ADDRWIDTH = 4;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [DATAWIDTH-1:0] shift_input;
    logic [AMTWIDTH-2:0] shift_amount;
    logic right_shift;
    logic zero_force;
    logic [ADDRWIDTH-1:0] dest_addr;
  } shift_op_t;
endpackage

// File: rtl/shift_count_decode.sv
// shift_count_decode: signed shift count to direction, magnitude and most-negative flag
module shift_count_decode #(
  parameter int AMTWIDTH = 5
) (
  input logic [AMTWIDTH-1:0] count,
  output logic right_shift,
  output logic [AMTWIDTH-2:0] shift_amount,
  output logic zero_force
);
  logic [AMTWIDTH-2:0] lo;
  assign lo = count[AMTWIDTH-2:0];
  assign right_shift = count[AMTWIDTH-1];
  // negating the low bits alone gives |c|, and wraps the most negative count to 0
  assign shift_amount = right_shift ? -lo : lo;
  assign zero_force = right_shift && lo == '0;
endmodule

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: registered issue stage with 2-entry skid buffer feeding the shifter
import shift_pkg::*;

module shift_operand_stage #(
  parameter int DATAWIDTH = shift_pkg::DATAWIDTH,
  parameter int AMTWIDTH = shift_pkg::AMTWIDTH,
  parameter int ADDRWIDTH = shift_pkg::ADDRWIDTH
) (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic in_valid,
  output logic in_ready,
  input logic is_imm,
  input logic [DATAWIDTH-1:0] rdest_data,
  input logic [DATAWIDTH-1:0] rsrc_data,
  input logic [AMTWIDTH-1:0] imm,
  input logic [ADDRWIDTH-1:0] dest_addr,
  output logic out_valid,
  input logic out_ready,
  output logic [DATAWIDTH-1:0] shift_input,
  output logic [AMTWIDTH-2:0] shift_amount,
  output logic right_shift,
  output logic zero_force,
  output logic [ADDRWIDTH-1:0] out_dest_addr
);
  state_t state, nxt;
  shift_op_t main_op, skid_op, in_op;
  logic [AMTWIDTH-1:0] count;
  logic xin, xout, unused_hi;
  assign unused_hi = ^rsrc_data[DATAWIDTH-1:AMTWIDTH];
  assign count = is_imm ? imm : rsrc_data[AMTWIDTH-1:0];
  shift_count_decode #(.AMTWIDTH(AMTWIDTH)) u_dec (
    .count(count),
    .right_shift(in_op.right_shift),
    .shift_amount(in_op.shift_amount),
    .zero_force(in_op.zero_force)
  );
  assign in_op.shift_input = rdest_data;
  assign in_op.dest_addr = dest_addr;
  assign xin = in_valid && in_ready;
  assign xout = out_valid && out_ready;
  always_comb begin
    nxt = flush ? EMPTY :
          state == EMPTY ? (xin ? ONE : EMPTY) :
          state == ONE ? (xin ? (xout ? ONE : TWO) : (xout ? EMPTY : ONE)) :
          (xout ? ONE : TWO);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      main_op <= '0;
      skid_op <= '0;
    end else begin
      state <= nxt;
      in_ready <= nxt != TWO;
      out_valid <= nxt != EMPTY;
      if (!flush && xin && (state == EMPTY || (state == ONE && xout))) main_op <= in_op;
      else if (state == TWO && xout) main_op <= skid_op;
      if (!flush && xin && state == ONE && !xout) skid_op <= in_op;
    end
  end
  assign shift_input = main_op.shift_input;
  assign shift_amount = main_op.shift_amount;
  assign right_shift = main_op.right_shift;
  assign zero_force = main_op.zero_force;
  assign out_dest_addr = main_op.dest_addr;
endmodule
